filtr_out_capture: RTL
======================

# filtr_out_capture

Receive-side counterpart of the sample feeder that drives `filtr_top`. It watches the `sample` strobe and the `filter_done` handshake, and captures each filter result `data_out` into a small FIFO for downstream reading. It also measures per-sample processing latency in `clk` cycles and flags missed or late results. It sits directly after `filtr_top` and shares its `clk`/`reset` domain.

## Interface
- `DATA_SIZE`, 24, result word width (matches filter `data_out`)
- `DEPTH_LOG2`, 4, FIFO depth = 2^DEPTH_LOG2 entries
- `TIMEOUT`, 50000, max cycles from sample to done (one 2 kHz period at 100 MHz)
- `LAT_W`, 16, latency register width; must satisfy 2^LAT_W > TIMEOUT
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `sample`  in  1  sample strobe seen by the filter (multi-cycle pulse)
- `filter_done`  in  1  filter result-ready (level or pulse)
- `data_in`  in  DATA_SIZE  filter `data_out`
- `rd_en`  in  1  pop request
- `rd_data`  out  DATA_SIZE  FIFO head (show-ahead)
- `rd_valid`  out  1  FIFO not empty
- `count`  out  DEPTH_LOG2+1  FIFO occupancy
- `last_latency`  out  LAT_W  latency of last captured sample
- `overrun`  out  1  sticky: result dropped because FIFO full
- `timeout`  out  1  sticky: result missing or late
- `clear_flags`  in  1  synchronous clear of `overrun`/`timeout`

## Operation
- All inputs are synchronous to `clk`; the block has no synchronizers.
- Rise detection: `s_rise = sample & ~sample_q` and `d_rise = filter_done & ~done_q`, with the `_q` registers reset to 0.
- FSM states and transitions:
  - IDLE: on `s_rise`, go to WAIT_DONE with `cnt=0`. `d_rise` is ignored in IDLE.
  - WAIT_DONE: `cnt` increments each cycle.
    - On `d_rise`: write `data_in` to the FIFO, set `last_latency=cnt+1`, go to IDLE.
    - If `cnt+1 == TIMEOUT` with no `d_rise`: set `timeout` and go to IDLE. No write occurs.
    - On `s_rise` without `d_rise`: set `timeout` and restart WAIT_DONE with `cnt=0`.
    - On `s_rise` and `d_rise` in the same cycle: capture first, then restart WAIT_DONE with `cnt=0`. `timeout` is not set.
- FIFO:
  - Write while full (and no simultaneous pop): word dropped, `overrun` set.
  - Write and pop together when full: both take effect, `count` stays at 2^DEPTH_LOG2.
  - Pop while empty: ignored. `rd_data` is don't-care when `!rd_valid`.
  - Pointers wrap modulo 2^DEPTH_LOG2.
- `clear_flags` clears both sticky flags. If a flag-setting event occurs in the same cycle, the set wins.

## Timing
- Reset values: FSM=IDLE, `cnt=0`, FIFO empty, `rd_valid=0`, `count=0`, `rd_data=0`, `last_latency=0`, `overrun=0`, `timeout=0`.
- Latency: `d_rise` on cycle N after the `s_rise` cycle 0 gives `last_latency=N`. Both `last_latency` and the FIFO write are registered at the end of cycle N.
- `rd_valid` rises 1 cycle after a write into an empty FIFO. `rd_data` shows the head in the same cycle.
- Pop: `rd_en & rd_valid` at edge k advances the head; the new head and `count` appear after edge k.
- Reset asserted mid-operation: all state returns to reset values immediately and FIFO contents are discarded. The first `s_rise` after release starts fresh.

## Structure
- Shared package `filtr_pkg`: `DATA_SIZE`, FSM state encoding (IDLE, WAIT_DONE), default `TIMEOUT`.
- Sub-module `sync_fifo` (parameters DATA_SIZE, DEPTH_LOG2; ports `wr_en`/`wr_data`/`rd_en`/`rd_data`/`count`/`full`/`empty`). The FSM, latency counter and flags stay in the top.

## Test plan
- Single sample: `sample` high 5 cycles, `filter_done` pulse 40 cycles after the rise with `data_in=24'h12ABCD` -> `rd_valid=1`, `rd_data=24'h12ABCD`, `last_latency=40`, no flags.
- 17 samples with no reads, `DEPTH_LOG2=4` -> `count=16`, `overrun=1`, and the 17th word is absent. Pop all 16 -> the first 16 words come out in order, then `rd_valid=0`.
- `sample` rise with no done, `TIMEOUT=100` -> `timeout=1` 100 cycles after the rise, FSM back in IDLE, nothing written. `clear_flags` -> `timeout=0`.
- Second `s_rise` at cycle 30 with no done, then done at cycle 10 after it -> `timeout=1`, one word captured, `last_latency=10`.
- Same-cycle `d_rise` and `s_rise` -> word captured, no timeout, next done at +20 -> `last_latency=20`.
- `reset` low during WAIT_DONE with 3 words queued -> all outputs at reset values. After release, a new sample and done capture normally.

Source files
------------

// File: rtl/filtr_pkg.sv
// filtr_pkg: shared constants and FSM encoding for the filter result capture path
package filtr_pkg;
  localparam int DATA_SIZE = 24;
  localparam int TIMEOUT = 50000;
  typedef enum logic {IDLE = 1'b0, WAIT_DONE = 1'b1} state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO; write while full is dropped unless a pop frees the slot
module sync_fifo #(
  parameter int DATA_SIZE = 24,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_SIZE-1:0]  wr_data,
  input  logic                  rd_en,
  output logic [DATA_SIZE-1:0]  rd_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic do_wr, do_rd;
  assign empty = count == '0;
  assign full = count == (DEPTH_LOG2+1)'(DEPTH);
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + DEPTH_LOG2'(do_wr);
      rd_ptr <= rd_ptr + DEPTH_LOG2'(do_rd);
      count <= count + (DEPTH_LOG2+1)'(do_wr) - (DEPTH_LOG2+1)'(do_rd);
    end
endmodule

// File: rtl/filtr_out_capture.sv
// filtr_out_capture: captures filter results into a FIFO, measures sample-to-done latency, flags overrun/timeout
module filtr_out_capture #(
  parameter int DATA_SIZE = filtr_pkg::DATA_SIZE,
  parameter int DEPTH_LOG2 = 4,
  parameter int TIMEOUT = filtr_pkg::TIMEOUT,
  parameter int LAT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample,
  input  logic                  filter_done,
  input  logic [DATA_SIZE-1:0]  data_in,
  input  logic                  rd_en,
  output logic [DATA_SIZE-1:0]  rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   count,
  output logic [LAT_W-1:0]      last_latency,
  output logic                  overrun,
  output logic                  timeout,
  input  logic                  clear_flags
);
  import filtr_pkg::*;
  state_t state, state_nx;
  logic sample_q, done_q, s_rise, d_rise, hit;
  logic wr, to_evt, drop, full, empty;
  logic [LAT_W-1:0] cnt, cnt_inc;
  assign s_rise = sample & ~sample_q;
  assign d_rise = filter_done & ~done_q;
  assign cnt_inc = cnt + LAT_W'(1);
  assign hit = cnt_inc == LAT_W'(TIMEOUT);
  assign rd_valid = ~empty;
  assign drop = wr & full & ~(rd_en & ~empty);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // a new sample always (re)starts the wait, even when it coincides with a capture
  always_comb
    state_nx = s_rise ? WAIT_DONE : (state == WAIT_DONE && !(d_rise || hit)) ? WAIT_DONE : IDLE;
  always_comb begin
    wr = (state == WAIT_DONE) & d_rise;
    to_evt = (state == WAIT_DONE) & ~d_rise & (s_rise | hit);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sample_q <= 1'b0;
      done_q <= 1'b0;
      cnt <= '0;
      last_latency <= '0;
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      sample_q <= sample;
      done_q <= filter_done;
      cnt <= s_rise ? '0 : (state == WAIT_DONE) ? cnt_inc : cnt;
      last_latency <= wr ? cnt_inc : last_latency;
      overrun <= drop | (overrun & ~clear_flags);
      timeout <= to_evt | (timeout & ~clear_flags);
    end
  sync_fifo #(.DATA_SIZE(DATA_SIZE), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk(clk),
    .reset(reset),
    .wr_en(wr),
    .wr_data(data_in),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .count(count),
    .full(full),
    .empty(empty)
  );
endmodule
